product_accumulator: RTL and testbench

- Downstream stage of the 4x4 array multiplier.
- Consumes the 8-bit unsigned product stream and sums consecutive products into a wider result, forming a dot-product or MAC frame.
- Frame boundaries are set by a last flag or by a maximum term count.
- Valid/ready handshake on both sides; the result is held until it is accepted.

---
 rtl/mac_pkg.sv | 15 +
 rtl/acc_sat_add.sv | 22 ++
 rtl/product_accumulator.sv | 101 ++++++++++
 tb/tb_product_accumulator.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate path: the product width
// fixed by the 4x4 array multiplier and the accumulator FSM state encoding.
package mac_pkg;

    // Width of the unsigned product coming out of the 4x4 multiplier.
    localparam int PROD_W = 8;

    // ACC: collecting products of the current frame.
    // HOLD: a finished frame result is waiting to be accepted downstream.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// Saturating accumulate step: adds a zero-extended product to the running
// sum and clamps to all-ones once the sum has overflowed. The overflow flag
// is sticky, so a frame that saturated once stays saturated.
module acc_sat_add #(
    parameter int PROD_W = mac_pkg::PROD_W,
    parameter int ACC_W  = 12
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    input  logic              ovf_in,
    output logic [ACC_W-1:0]  sat,
    output logic              ovf_out
);

    // One extra bit on top of the accumulator width captures the carry-out.
    logic [ACC_W:0] nsum;

    assign nsum    = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign ovf_out = nsum[ACC_W] | ovf_in;
    assign sat     = ovf_out ? {ACC_W{1'b1}} : nsum[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums consecutive multiplier products into one frame result. A frame ends
// on a beat flagged last or when MAX_TERMS products have been taken. The
// result is held in output registers until the consumer accepts it; while
// it is held, the product input is back-pressured.
module product_accumulator #(
    parameter int PROD_W    = mac_pkg::PROD_W,
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    input  logic              prod_last_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  sum_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              ovf_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i
);

    import mac_pkg::*;

    state_t            state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              ovf_reg;

    logic [ACC_W-1:0]  sat_next;
    logic              ovf_next;
    logic [CNT_W-1:0]  count_next;
    logic              beat;
    logic              frame_close;

    // Saturating adder for the running sum.
    acc_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_acc_sat_add (
        .acc     (acc_reg),
        .prod    (prod_i),
        .ovf_in  (ovf_reg),
        .sat     (sat_next),
        .ovf_out (ovf_next)
    );

    // Upstream may only push while collecting; HOLD back-pressures it.
    assign prod_ready_o = (state_reg == ACC);
    assign beat         = prod_valid_i & prod_ready_o;
    assign count_next   = count_reg + CNT_W'(1);
    // A frame closes on an explicit last flag or when the term limit is hit;
    // count_reg never itself reaches MAX_TERMS, so the counter cannot wrap.
    assign frame_close  = prod_last_i | (count_next == CNT_W'(MAX_TERMS));

    // Frame FSM: accumulate beats, latch the result on close, hold it until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ACC;
            acc_reg     <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
            sum_o       <= '0;
            cnt_o       <= '0;
            ovf_o       <= 1'b0;
            sum_valid_o <= 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (beat) begin
                        if (frame_close) begin
                            sum_o       <= sat_next;
                            cnt_o       <= count_next;
                            ovf_o       <= ovf_next;
                            sum_valid_o <= 1'b1;
                            acc_reg     <= '0;
                            count_reg   <= '0;
                            ovf_reg     <= 1'b0;
                            state_reg   <= HOLD;
                        end else begin
                            acc_reg     <= sat_next;
                            count_reg   <= count_next;
                            ovf_reg     <= ovf_next;
                        end
                    end
                end
                HOLD: begin
                    if (sum_ready_i) begin
                        sum_valid_o <= 1'b0;
                        state_reg   <= ACC;
                    end
                end
                default: begin
                    state_reg <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: one default instance (ACC_W=12) and one
// narrow instance (ACC_W=10) share the same stimulus. A frame model keeps
// the plain arithmetic total of the frame and clamps it to each width.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  prod = 8'd0;
    logic        prod_valid = 1'b0;
    logic        prod_last = 1'b0;
    logic        sum_ready = 1'b0;

    logic        ready12, ready10;
    logic [11:0] sum12;
    logic [9:0]  sum10;
    logic [4:0]  cnt12, cnt10;
    logic        ovf12, ovf10, valid12, valid10;

    int total_n = 0;
    int bad_n   = 0;

    // Frame model: arithmetic total and term count of the open frame.
    int m_total = 0;
    int m_cnt   = 0;
    int e_sum12, e_sum10, e_cnt;
    bit e_ovf12, e_ovf10;
    bit closed;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(12), .MAX_TERMS(16)) dut12 (
        .clk          (clk),
        .rst_n        (rst_n),
        .prod_i       (prod),
        .prod_valid_i (prod_valid),
        .prod_last_i  (prod_last),
        .prod_ready_o (ready12),
        .sum_o        (sum12),
        .cnt_o        (cnt12),
        .ovf_o        (ovf12),
        .sum_valid_o  (valid12),
        .sum_ready_i  (sum_ready)
    );

    product_accumulator #(.ACC_W(10), .MAX_TERMS(16)) dut10 (
        .clk          (clk),
        .rst_n        (rst_n),
        .prod_i       (prod),
        .prod_valid_i (prod_valid),
        .prod_last_i  (prod_last),
        .prod_ready_o (ready10),
        .sum_o        (sum10),
        .cnt_o        (cnt10),
        .ovf_o        (ovf10),
        .sum_valid_o  (valid10),
        .sum_ready_i  (sum_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one product (waiting a bounded time for ready) and update the model.
    task automatic beat(input logic [7:0] p, input logic l);
        int n = 0;
        while (!ready12 && n < 50) begin
            tick();
            n++;
        end
        total_n++;
        if (!ready12) begin
            bad_n++;
            $display("FAIL beat_wait ready=%0b want=1 after %0d cycles", ready12, n);
        end
        prod_valid = 1'b1;
        prod       = p;
        prod_last  = l;
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        prod       = 8'($urandom);
        m_total += int'(p);
        m_cnt++;
        closed = (l == 1'b1) || (m_cnt == 16);
        if (closed) begin
            e_sum12 = (m_total > 4095) ? 4095 : m_total;
            e_ovf12 = (m_total > 4095);
            e_sum10 = (m_total > 1023) ? 1023 : m_total;
            e_ovf10 = (m_total > 1023);
            e_cnt   = m_cnt;
            m_total = 0;
            m_cnt   = 0;
        end
    endtask

    task automatic release_result();
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_n++; if (ready12 !== 1'b1 || ready10 !== 1'b1) begin bad_n++; $display("FAIL reset_ready got=%0b/%0b want=1", ready12, ready10); end
        total_n++; if (valid12 !== 1'b0 || valid10 !== 1'b0) begin bad_n++; $display("FAIL reset_valid got=%0b/%0b want=0", valid12, valid10); end
        total_n++; if (sum12 !== 12'd0 || sum10 !== 10'd0) begin bad_n++; $display("FAIL reset_sum got=%0d/%0d want=0", sum12, sum10); end
        total_n++; if (cnt12 !== 5'd0 || ovf12 !== 1'b0 || ovf10 !== 1'b0) begin bad_n++; $display("FAIL reset_cnt_ovf cnt=%0d ovf=%0b/%0b want=0", cnt12, ovf12, ovf10); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        sum_ready = 1'b1;
        beat(8'd225, 1'b0);
        beat(8'd225, 1'b0);
        beat(8'd225, 1'b1);
        sum_ready = 1'b1;
        total_n++; if (valid12 !== 1'b1) begin bad_n++; $display("FAIL basic_valid got=%0b want=1", valid12); end
        total_n++; if (sum12 !== 12'd675 || sum10 !== 10'd675) begin bad_n++; $display("FAIL basic_sum got=%0d/%0d want=675", sum12, sum10); end
        total_n++; if (cnt12 !== 5'd3 || ovf12 !== 1'b0) begin bad_n++; $display("FAIL basic_cnt_ovf cnt=%0d ovf=%0b want=3/0", cnt12, ovf12); end
        total_n++; if (ready12 !== 1'b0) begin bad_n++; $display("FAIL basic_ready_hold got=%0b want=0", ready12); end
        tick();
        sum_ready = 1'b0;
        total_n++; if (valid12 !== 1'b0 || ready12 !== 1'b1) begin bad_n++; $display("FAIL basic_after valid=%0b ready=%0b want=0/1", valid12, ready12); end
        $display("test_basic done sum=%0d cnt=%0d", sum12, cnt12);
    endtask

    task automatic test_auto_close();
        sum_ready = 1'b0;
        for (int i = 0; i < 16; i++) beat(8'd1, 1'b0);
        total_n++; if (valid12 !== 1'b1 || sum12 !== 12'd16 || cnt12 !== 5'd16) begin bad_n++; $display("FAIL auto_close valid=%0b sum=%0d cnt=%0d want=1/16/16", valid12, sum12, cnt12); end
        prod_valid = 1'b1;
        prod       = 8'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_n++; if (ready12 !== 1'b0 || valid12 !== 1'b1) begin bad_n++; $display("FAIL auto_hold ready=%0b valid=%0b want=0/1", ready12, valid12); end
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        total_n++; if (valid12 !== 1'b0 || ready12 !== 1'b1) begin bad_n++; $display("FAIL auto_exit valid=%0b ready=%0b want=0/1", valid12, ready12); end
        tick();
        prod_valid = 1'b0;
        m_total = 1;
        m_cnt   = 1;
        beat(8'd0, 1'b1);
        total_n++; if (valid12 !== 1'b1 || sum12 !== 12'd1 || cnt12 !== 5'd2) begin bad_n++; $display("FAIL auto_17th valid=%0b sum=%0d cnt=%0d want=1/1/2", valid12, sum12, cnt12); end
        release_result();
        $display("test_auto_close done");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) beat(8'd225, 1'b0);
        beat(8'd225, 1'b1);
        total_n++; if (sum10 !== 10'd1023 || ovf10 !== 1'b1 || cnt10 !== 5'd5) begin bad_n++; $display("FAIL sat_narrow sum=%0d ovf=%0b cnt=%0d want=1023/1/5", sum10, ovf10, cnt10); end
        total_n++; if (sum12 !== 12'd1125 || ovf12 !== 1'b0) begin bad_n++; $display("FAIL sat_wide sum=%0d ovf=%0b want=1125/0", sum12, ovf12); end
        release_result();
        beat(8'd7, 1'b1);
        total_n++; if (sum10 !== 10'd7 || ovf10 !== 1'b0 || cnt10 !== 5'd1) begin bad_n++; $display("FAIL sat_clear sum=%0d ovf=%0b cnt=%0d want=7/0/1", sum10, ovf10, cnt10); end
        release_result();
        $display("test_saturation done");
    endtask

    task automatic test_backpressure();
        beat(8'd10, 1'b0);
        beat(8'd20, 1'b1);
        prod_valid = 1'b1;
        prod       = 8'd9;
        prod_last  = 1'b1;
        sum_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_n++; if (ready12 !== 1'b0 || valid12 !== 1'b1 || sum12 !== 12'd30 || cnt12 !== 5'd2) begin bad_n++; $display("FAIL bp_hold ready=%0b valid=%0b sum=%0d cnt=%0d want=0/1/30/2", ready12, valid12, sum12, cnt12); end
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        total_n++; if (ready12 !== 1'b1 || valid12 !== 1'b0) begin bad_n++; $display("FAIL bp_exit ready=%0b valid=%0b want=1/0", ready12, valid12); end
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        total_n++; if (valid12 !== 1'b1 || sum12 !== 12'd9 || cnt12 !== 5'd1) begin bad_n++; $display("FAIL bp_accept valid=%0b sum=%0d cnt=%0d want=1/9/1", valid12, sum12, cnt12); end
        release_result();
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid();
        beat(8'd100, 1'b0);
        beat(8'd100, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_total = 0;
        m_cnt   = 0;
        for (int i = 0; i < 2; i++) begin
            total_n++; if (valid12 !== 1'b0 || ready12 !== 1'b1) begin bad_n++; $display("FAIL rstmid_idle valid=%0b ready=%0b want=0/1", valid12, ready12); end
            tick();
        end
        beat(8'd4, 1'b1);
        total_n++; if (valid12 !== 1'b1 || sum12 !== 12'd4 || cnt12 !== 5'd1) begin bad_n++; $display("FAIL rstmid_frame valid=%0b sum=%0d cnt=%0d want=1/4/1", valid12, sum12, cnt12); end
        release_result();
        $display("test_reset_mid done");
    endtask

    task automatic test_single_zero();
        beat(8'd0, 1'b1);
        total_n++; if (valid12 !== 1'b1 || sum12 !== 12'd0 || cnt12 !== 5'd1) begin bad_n++; $display("FAIL single_zero valid=%0b sum=%0d cnt=%0d want=1/0/1", valid12, sum12, cnt12); end
        release_result();
        $display("test_single_zero done");
    endtask

    task automatic test_random();
        int len;
        int gap;
        int hold;
        logic [7:0] p;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    prod      = 8'($urandom);
                    prod_last = 1'($urandom);
                    tick();
                    total_n++; if (valid12 !== 1'b0 || valid10 !== 1'b0) begin bad_n++; $display("FAIL rnd_idle valid=%0b/%0b want=0", valid12, valid10); end
                end
                prod_last = 1'b0;
                p = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
                beat(p, (k == len - 1));
                if (closed) begin
                    total_n++; if (valid12 !== 1'b1 || valid10 !== 1'b1) begin bad_n++; $display("FAIL rnd_valid got=%0b/%0b want=1", valid12, valid10); end
                    total_n++; if (sum12 !== 12'(e_sum12) || ovf12 !== e_ovf12) begin bad_n++; $display("FAIL rnd_sum12 got=%0d/%0b want=%0d/%0b", sum12, ovf12, e_sum12, e_ovf12); end
                    total_n++; if (sum10 !== 10'(e_sum10) || ovf10 !== e_ovf10) begin bad_n++; $display("FAIL rnd_sum10 got=%0d/%0b want=%0d/%0b", sum10, ovf10, e_sum10, e_ovf10); end
                    total_n++; if (cnt12 !== 5'(e_cnt) || cnt10 !== 5'(e_cnt)) begin bad_n++; $display("FAIL rnd_cnt got=%0d/%0d want=%0d", cnt12, cnt10, e_cnt); end
                    $display("frame %0d closed sum12=%0d sum10=%0d cnt=%0d ovf10=%0b", f, sum12, sum10, cnt12, ovf10);
                    hold = $urandom_range(0, 3);
                    for (int h = 0; h < hold; h++) begin
                        prod_valid = 1'($urandom);
                        prod       = 8'($urandom);
                        prod_last  = 1'($urandom);
                        tick();
                        total_n++; if (ready12 !== 1'b0 || sum12 !== 12'(e_sum12) || cnt12 !== 5'(e_cnt)) begin bad_n++; $display("FAIL rnd_hold ready=%0b sum=%0d cnt=%0d want=0/%0d/%0d", ready12, sum12, cnt12, e_sum12, e_cnt); end
                    end
                    prod_valid = 1'b0;
                    prod_last  = 1'b0;
                    release_result();
                    total_n++; if (valid12 !== 1'b0 || ready12 !== 1'b1) begin bad_n++; $display("FAIL rnd_release valid=%0b ready=%0b want=0/1", valid12, ready12); end
                end else begin
                    total_n++; if (valid12 !== 1'b0 || valid10 !== 1'b0) begin bad_n++; $display("FAIL rnd_open valid=%0b/%0b want=0", valid12, valid10); end
                end
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_auto_close();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_single_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
